// File: rtl/display_pkg.sv
// Shared geometry constants and renderer state type for the text renderer.
package display_pkg;

  localparam int unsigned DISP_PAGES          = 8;
  localparam int unsigned DISP_WORDS_PER_PAGE = 120;
  localparam int unsigned DISP_ADDR_W         = 10;
  localparam int unsigned CHAR_COLS           = 40;
  localparam int unsigned GLYPH_W             = 5;
  localparam int unsigned CELL_WORDS          = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_WRITE,
    ST_CLEAR
  } render_state_t;

endpackage

// File: rtl/display_text_renderer_if.sv
// Command input and display word-write bus of the text renderer.
interface display_text_renderer_if;
  import display_pkg::*;

  logic                   cmd_valid_in;
  logic                   cmd_ready_o;
  logic                   cmd_clear_in;
  logic [2:0]             cmd_row_in;
  logic [5:0]             cmd_col_in;
  logic [6:0]             cmd_char_in;
  logic                   cmd_invert_in;
  logic [DISP_ADDR_W-1:0] addr_o;
  logic [15:0]            data_o;
  logic                   we_o;
  logic                   err_o;
  logic                   busy_o;

  modport master (
    output cmd_valid_in, cmd_clear_in, cmd_row_in, cmd_col_in, cmd_char_in, cmd_invert_in,
    input  cmd_ready_o, addr_o, data_o, we_o, err_o, busy_o
  );

  modport slave (
    input  cmd_valid_in, cmd_clear_in, cmd_row_in, cmd_col_in, cmd_char_in, cmd_invert_in,
    output cmd_ready_o, addr_o, data_o, we_o, err_o, busy_o
  );

endinterface

// File: rtl/font_rom_5x7.sv
// 1024 x 8 font ROM, address {char, column}, registered read (1 cycle).
// Glyph table holds digits and upper-case letters; other codes are blank.
module font_rom_5x7 (
  input  logic       clk_in,
  input  logic [9:0] addr,
  output logic [7:0] data
);

  // Columns packed left to right: [39:32] = column 0 ... [7:0] = column 4.
  function automatic logic [39:0] glyph_of(input logic [6:0] ch);
    case (ch)
      7'h30: glyph_of = 40'h3E_51_49_45_3E;
      7'h31: glyph_of = 40'h00_42_7F_40_00;
      7'h32: glyph_of = 40'h42_61_51_49_46;
      7'h33: glyph_of = 40'h21_41_45_4B_31;
      7'h34: glyph_of = 40'h18_14_12_7F_10;
      7'h35: glyph_of = 40'h27_45_45_45_39;
      7'h36: glyph_of = 40'h3C_4A_49_49_30;
      7'h37: glyph_of = 40'h01_71_09_05_03;
      7'h38: glyph_of = 40'h36_49_49_49_36;
      7'h39: glyph_of = 40'h06_49_49_29_1E;
      7'h41: glyph_of = 40'h7E_11_11_11_7E;
      7'h42: glyph_of = 40'h7F_49_49_49_36;
      7'h43: glyph_of = 40'h3E_41_41_41_22;
      7'h44: glyph_of = 40'h7F_41_41_22_1C;
      7'h45: glyph_of = 40'h7F_49_49_49_41;
      7'h46: glyph_of = 40'h7F_09_09_09_01;
      7'h47: glyph_of = 40'h3E_41_49_49_7A;
      7'h48: glyph_of = 40'h7F_08_08_08_7F;
      7'h49: glyph_of = 40'h00_41_7F_41_00;
      7'h4A: glyph_of = 40'h20_40_41_3F_01;
      7'h4B: glyph_of = 40'h7F_08_14_22_41;
      7'h4C: glyph_of = 40'h7F_40_40_40_40;
      7'h4D: glyph_of = 40'h7F_02_0C_02_7F;
      7'h4E: glyph_of = 40'h7F_04_08_10_7F;
      7'h4F: glyph_of = 40'h3E_41_41_41_3E;
      7'h50: glyph_of = 40'h7F_09_09_09_06;
      7'h51: glyph_of = 40'h3E_41_51_21_5E;
      7'h52: glyph_of = 40'h7F_09_19_29_46;
      7'h53: glyph_of = 40'h46_49_49_49_31;
      7'h54: glyph_of = 40'h01_01_7F_01_01;
      7'h55: glyph_of = 40'h3F_40_40_40_3F;
      7'h56: glyph_of = 40'h1F_20_40_20_1F;
      7'h57: glyph_of = 40'h3F_40_38_40_3F;
      7'h58: glyph_of = 40'h63_14_08_14_63;
      7'h59: glyph_of = 40'h07_08_70_08_07;
      7'h5A: glyph_of = 40'h61_51_49_45_43;
      default: glyph_of = '0;
    endcase
  endfunction

  logic [39:0] glyph;
  logic [7:0]  column;

  // Select one glyph column; indices 5..7 read as blank.
  always_comb begin
    glyph = glyph_of(addr[9:3]);
    case (addr[2:0])
      3'd0:    column = glyph[39:32];
      3'd1:    column = glyph[31:24];
      3'd2:    column = glyph[23:16];
      3'd3:    column = glyph[15:8];
      3'd4:    column = glyph[7:0];
      default: column = '0;
    endcase
  end

  // Registered read port.
  always_ff @(posedge clk_in) begin
    data <= column;
  end

endmodule

// File: rtl/display_text_renderer.sv
// Text renderer: turns draw-char / clear commands into display word writes.
module display_text_renderer
  import display_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    reset_in,
  display_text_renderer_if.slave  bus
);

  render_state_t          state;
  logic [2:0]             row_r;
  logic [5:0]             col_r;
  logic [6:0]             char_r;
  logic                   inv_r;
  logic [2:0]             idx;
  logic                   cap_en;
  logic [2:0]             cap_idx;
  logic [7:0]             glyph [GLYPH_W];
  logic [1:0]             wk;
  logic [7:0]             rom_data;
  logic [DISP_ADDR_W-1:0] addr_r;
  logic [15:0]            data_r;
  logic                   we_r;
  logic                   err_r;

  logic [6:0]             base;
  logic [3:0][15:0]       words;
  logic [1:0]             nk;
  logic [15:0]            next_data;
  logic [DISP_ADDR_W-1:0] next_addr;

  font_rom_5x7 u_rom (
    .clk_in (clk_in),
    .addr   ({char_r, idx}),
    .data   (rom_data)
  );

  // Next word of the current character cell: word 0 from WAIT, word wk+1 from WRITE.
  always_comb begin
    base      = {col_r, 1'b0} + {1'b0, col_r};
    words     = '0;
    words[0]  = {glyph[1], glyph[0]};
    words[1]  = {glyph[3], glyph[2]};
    words[2]  = {8'h00, glyph[4]};
    nk        = (state == ST_WAIT) ? 2'd0 : wk + 2'd1;
    next_data = words[nk] ^ {16{inv_r}};
    next_addr = {row_r, base + 7'(nk)};
  end

  // Renderer FSM with glyph capture and registered write-port outputs.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state   <= ST_IDLE;
      row_r   <= '0;
      col_r   <= '0;
      char_r  <= '0;
      inv_r   <= 1'b0;
      idx     <= '0;
      cap_en  <= 1'b0;
      cap_idx <= '0;
      wk      <= '0;
      addr_r  <= '0;
      data_r  <= '0;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      for (int unsigned i = 0; i < GLYPH_W; i++) glyph[i] <= '0;
    end else begin
      err_r  <= 1'b0;
      cap_en <= 1'b0;
      // ROM data lags the presented column index by one cycle.
      if (cap_en) glyph[cap_idx] <= (char_r < 7'h20) ? 8'h00 : rom_data;
      case (state)
        ST_IDLE: begin
          we_r <= 1'b0;
          if (bus.cmd_valid_in) begin
            if (bus.cmd_clear_in) begin
              inv_r  <= bus.cmd_invert_in;
              we_r   <= 1'b1;
              addr_r <= '0;
              data_r <= {16{bus.cmd_invert_in}};
              state  <= ST_CLEAR;
            end else if (bus.cmd_col_in >= 6'(CHAR_COLS)) begin
              err_r <= 1'b1;
            end else begin
              row_r  <= bus.cmd_row_in;
              col_r  <= bus.cmd_col_in;
              char_r <= bus.cmd_char_in;
              inv_r  <= bus.cmd_invert_in;
              idx    <= '0;
              state  <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          cap_en  <= 1'b1;
          cap_idx <= idx;
          if (idx == 3'(GLYPH_W - 1)) state <= ST_WAIT;
          else                        idx   <= idx + 3'd1;
        end
        ST_WAIT: begin
          we_r   <= 1'b1;
          addr_r <= next_addr;
          data_r <= next_data;
          wk     <= '0;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          if (wk == 2'(CELL_WORDS - 1)) begin
            we_r  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            addr_r <= next_addr;
            data_r <= next_data;
            wk     <= wk + 2'd1;
          end
        end
        ST_CLEAR: begin
          if (addr_r == {3'(DISP_PAGES - 1), 7'(DISP_WORDS_PER_PAGE - 1)}) begin
            we_r  <= 1'b0;
            state <= ST_IDLE;
          end else if (addr_r[6:0] == 7'(DISP_WORDS_PER_PAGE - 1)) begin
            addr_r <= {addr_r[9:7] + 3'd1, 7'd0};
          end else begin
            addr_r <= addr_r + 10'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = (state == ST_IDLE) && !reset_in;
  assign bus.busy_o      = ~bus.cmd_ready_o;
  assign bus.addr_o      = addr_r;
  assign bus.data_o      = data_r;
  assign bus.we_o        = we_r;
  assign bus.err_o       = err_r;

endmodule

// File: tb/tb_display_text_renderer.sv
// Self-checking bench for display_text_renderer: directed table, corner sequences, random commands.
module tb_display_text_renderer;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;

  display_text_renderer_if bus();

  display_text_renderer dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         wq[$];    // observed writes
  wr_t         ew[$];    // expected writes
  int unsigned errq[$];  // observed err pulses
  int unsigned eerr[$];  // expected err pulses

  int vectors     = 0;
  int miscompares = 0;

  bit [39:0] font [128];  // column 0 in [39:32]

  always @(negedge clk_in) begin
    wr_t w;
    if (bus.we_o === 1'b1) begin
      w.cyc = cyc; w.addr = bus.addr_o; w.data = bus.data_o;
      wq.push_back(w);
    end
    if (bus.err_o === 1'b1) errq.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int unsigned c, input logic [9:0] a, input logic [15:0] d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    ew.push_back(w);
  endtask

  // Reference: paint the 6 pixel columns of the cell into the page, then emit the 3 touched words.
  task automatic model_char(input int unsigned t, input bit [2:0] row, input bit [5:0] col,
                            input bit [6:0] ch, input bit inv);
    bit [15:0]   img [3];
    bit [7:0]    pix;
    bit [39:0]   g;
    int unsigned p;
    if (col >= 40) begin
      eerr.push_back(t + 1);
      return;
    end
    g = font[ch];
    for (int k = 0; k < 3; k++) img[k] = '0;
    for (int unsigned j = 0; j < 6; j++) begin
      pix = (j < 5 && ch >= 7'h20) ? g[39 - 8*j -: 8] : 8'h00;
      if (inv) pix = ~pix;
      p = 6*col + j;
      img[p/2 - 3*col][8*(p%2) +: 8] = pix;
    end
    for (int unsigned k = 0; k < 3; k++)
      push_exp(t + 7 + k, {row, 7'(3*col + k)}, img[k]);
  endtask

  task automatic model_clear(input int unsigned t, input bit inv, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      push_exp(t + 1 + i, {3'(i / 120), 7'(i % 120)}, inv ? 16'hFFFF : 16'h0000);
  endtask

  task automatic compare_run(input string name);
    int unsigned n;
    check({name, " write count"}, wq.size(), ew.size());
    n = (wq.size() < ew.size()) ? wq.size() : ew.size();
    for (int unsigned i = 0; i < n; i++) begin
      check({name, " write cycle"}, wq[i].cyc, ew[i].cyc);
      check({name, " write addr"},  wq[i].addr, ew[i].addr);
      check({name, " write data"},  wq[i].data, ew[i].data);
    end
    check({name, " err count"}, errq.size(), eerr.size());
    n = (errq.size() < eerr.size()) ? errq.size() : eerr.size();
    for (int unsigned i = 0; i < n; i++) check({name, " err cycle"}, errq[i], eerr[i]);
    wq.delete(); ew.delete(); errq.delete(); eerr.delete();
  endtask

  // Call right after a rising edge; returns just after the edge that takes the command.
  task automatic send(input bit clr, input bit [2:0] row, input bit [5:0] col,
                      input bit [6:0] ch, input bit inv, output int unsigned t);
    bit ok = 0;
    bus.cmd_clear_in = clr; bus.cmd_row_in = row; bus.cmd_col_in = col;
    bus.cmd_char_in = ch;   bus.cmd_invert_in = inv; bus.cmd_valid_in = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk_in);
      if (bus.cmd_ready_o) ok = 1;
    end
    t = cyc;
    if (!ok) check("send timeout", 0, 1);
    @(posedge clk_in); #1;
    bus.cmd_valid_in = 1'b0;
  endtask

  task automatic wait_ready(output int unsigned r);
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk_in);
      if (bus.cmd_ready_o) ok = 1;
    end
    r = cyc;
    if (!ok) check("ready timeout", 0, 1);
    @(posedge clk_in); #1;
  endtask

  typedef struct {
    bit          clr;
    bit [2:0]    row;
    bit [5:0]    col;
    bit [6:0]    ch;
    bit          inv;
    bit          err;
    bit [9:0]    a [3];
    bit [15:0]   d [3];
  } vec_t;

  vec_t tbl [6];

  initial begin
    int unsigned t, t2, r, badw;
    bit [2:0] rr; bit [5:0] rc; bit [6:0] rch; bit ri;

    foreach (font[i]) font[i] = '0;
    font[7'h30] = 40'h3E_51_49_45_3E; font[7'h31] = 40'h00_42_7F_40_00;
    font[7'h32] = 40'h42_61_51_49_46; font[7'h33] = 40'h21_41_45_4B_31;
    font[7'h34] = 40'h18_14_12_7F_10; font[7'h35] = 40'h27_45_45_45_39;
    font[7'h36] = 40'h3C_4A_49_49_30; font[7'h37] = 40'h01_71_09_05_03;
    font[7'h38] = 40'h36_49_49_49_36; font[7'h39] = 40'h06_49_49_29_1E;
    font[7'h41] = 40'h7E_11_11_11_7E; font[7'h42] = 40'h7F_49_49_49_36;
    font[7'h43] = 40'h3E_41_41_41_22; font[7'h44] = 40'h7F_41_41_22_1C;
    font[7'h45] = 40'h7F_49_49_49_41; font[7'h46] = 40'h7F_09_09_09_01;
    font[7'h47] = 40'h3E_41_49_49_7A; font[7'h48] = 40'h7F_08_08_08_7F;
    font[7'h49] = 40'h00_41_7F_41_00; font[7'h4A] = 40'h20_40_41_3F_01;
    font[7'h4B] = 40'h7F_08_14_22_41; font[7'h4C] = 40'h7F_40_40_40_40;
    font[7'h4D] = 40'h7F_02_0C_02_7F; font[7'h4E] = 40'h7F_04_08_10_7F;
    font[7'h4F] = 40'h3E_41_41_41_3E; font[7'h50] = 40'h7F_09_09_09_06;
    font[7'h51] = 40'h3E_41_51_21_5E; font[7'h52] = 40'h7F_09_19_29_46;
    font[7'h53] = 40'h46_49_49_49_31; font[7'h54] = 40'h01_01_7F_01_01;
    font[7'h55] = 40'h3F_40_40_40_3F; font[7'h56] = 40'h1F_20_40_20_1F;
    font[7'h57] = 40'h3F_40_38_40_3F; font[7'h58] = 40'h63_14_08_14_63;
    font[7'h59] = 40'h07_08_70_08_07; font[7'h5A] = 40'h61_51_49_45_43;

    tbl[0] = '{0, 3'd2, 6'd0,  7'h41, 0, 0, '{10'h100, 10'h101, 10'h102}, '{16'h117E, 16'h1111, 16'h007E}};
    tbl[1] = '{0, 3'd7, 6'd39, 7'h41, 1, 0, '{10'h3F5, 10'h3F6, 10'h3F7}, '{16'hEE81, 16'hEEEE, 16'hFF81}};
    tbl[2] = '{0, 3'd0, 6'd40, 7'h41, 0, 1, '{10'h000, 10'h000, 10'h000}, '{16'h0000, 16'h0000, 16'h0000}};
    tbl[3] = '{0, 3'd1, 6'd5,  7'h05, 0, 0, '{10'h08F, 10'h090, 10'h091}, '{16'h0000, 16'h0000, 16'h0000}};
    tbl[4] = '{0, 3'd0, 6'd1,  7'h1F, 1, 0, '{10'h003, 10'h004, 10'h005}, '{16'hFFFF, 16'hFFFF, 16'hFFFF}};
    tbl[5] = '{0, 3'd3, 6'd10, 7'h31, 0, 0, '{10'h19E, 10'h19F, 10'h1A0}, '{16'h4200, 16'h407F, 16'h0000}};

    bus.cmd_valid_in = 1'b0; bus.cmd_clear_in = 1'b0; bus.cmd_row_in = '0;
    bus.cmd_col_in = '0; bus.cmd_char_in = '0; bus.cmd_invert_in = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("reset we",    bus.we_o, 0);
      check("reset err",   bus.err_o, 0);
      check("reset ready", bus.cmd_ready_o, 0);
      check("reset busy",  bus.busy_o, 1);
    end
    check("reset addr", bus.addr_o, 0);
    check("reset data", bus.data_o, 0);
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    @(negedge clk_in);
    check("ready after reset", bus.cmd_ready_o, 1);
    check("busy after reset",  bus.busy_o, 0);
    @(posedge clk_in); #1;
    wq.delete(); errq.delete();

    // Directed table
    for (int v = 0; v < 6; v++) begin
      send(tbl[v].clr, tbl[v].row, tbl[v].col, tbl[v].ch, tbl[v].inv, t);
      if (tbl[v].err) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_in);
          check("err ready held", bus.cmd_ready_o, 1);
        end
        @(posedge clk_in); #1;
        check("tbl err count", errq.size(), 1);
        if (errq.size() > 0) check("tbl err cycle", errq[0], t + 1);
        check("tbl err writes", wq.size(), 0);
      end else begin
        wait_ready(r);
        check("tbl ready cycle", r, t + 10);
        check("tbl write count", wq.size(), 3);
        check("tbl no err", errq.size(), 0);
        for (int k = 0; k < 3 && k < wq.size(); k++) begin
          check("tbl cycle", wq[k].cyc, t + 7 + k);
          check("tbl addr",  wq[k].addr, tbl[v].a[k]);
          check("tbl data",  wq[k].data, tbl[v].d[k]);
        end
      end
      wq.delete(); errq.delete();
    end

    // Full clear
    send(1, 3'd0, 6'd0, 7'h00, 0, t);
    model_clear(t, 0, 960);
    wait_ready(r);
    check("clear ready cycle", r, t + 961);
    badw = 0;
    foreach (wq[i]) if (wq[i].addr[6:0] >= 7'd120) badw++;
    check("clear words 120..127 untouched", badw, 0);
    compare_run("clear");

    // Clear with invert and an out-of-range column: clear wins, no err
    send(1, 3'd5, 6'd50, 7'h41, 1, t);
    model_clear(t, 1, 960);
    wait_ready(r);
    check("clear inv ready cycle", r, t + 961);
    compare_run("clear inv");

    // Back-to-back with valid held through the busy period
    bus.cmd_clear_in = 0; bus.cmd_row_in = 3'd0; bus.cmd_col_in = 6'd1;
    bus.cmd_char_in = 7'h41; bus.cmd_invert_in = 0; bus.cmd_valid_in = 1;
    t = 0; t2 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (bus.cmd_ready_o) begin t = cyc; break; end
    end
    @(posedge clk_in); #1;
    bus.cmd_row_in = 3'd4; bus.cmd_col_in = 6'd2; bus.cmd_char_in = 7'h5A; bus.cmd_invert_in = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (bus.cmd_ready_o) begin t2 = cyc; break; end
    end
    @(posedge clk_in); #1;
    bus.cmd_valid_in = 0;
    check("back-to-back spacing", t2 - t, 10);
    model_char(t, 3'd0, 6'd1, 7'h41, 0);
    model_char(t2, 3'd4, 6'd2, 7'h5A, 1);
    wait_ready(r);
    compare_run("back-to-back");

    // Reset in the middle of a clear
    send(1, 3'd0, 6'd0, 7'h00, 0, t);
    for (int i = 0; i < 400 && cyc < t + 300; i++) begin
      @(posedge clk_in); #1;
    end
    reset_in = 1'b1;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("mid-clear reset we", bus.we_o, 0);
    check("mid-clear reset ready", bus.cmd_ready_o, 0);
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    @(posedge clk_in); #1;
    model_clear(t, 0, 300);
    compare_run("aborted clear");
    send(0, 3'd6, 6'd20, 7'h4D, 0, t);
    model_char(t, 3'd6, 6'd20, 7'h4D, 0);
    wait_ready(r);
    check("post-reset ready cycle", r, t + 10);
    compare_run("post-reset char");

    // Randomized commands against the reference model
    for (int n = 0; n < 40; n++) begin
      rr  = 3'($urandom_range(0, 7));
      rc  = 6'($urandom_range(0, 47));
      rch = (n % 3 == 0) ? 7'($urandom_range(8'h30, 8'h5A)) : 7'($urandom_range(0, 127));
      ri  = 1'($urandom_range(0, 1));
      send(0, rr, rc, rch, ri, t);
      model_char(t, rr, rc, rch, ri);
      if (rc < 40) begin
        wait_ready(r);
        check("rand ready cycle", r, t + 10);
      end else begin
        repeat (2) @(posedge clk_in);
        #1;
      end
      compare_run("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
